// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, request owner, byte-enable constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and single-port memory bus seen by mem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter_byte_merge.sv
// Combinational byte-lane merge for read-modify-write stores: lane i comes from the new word when be_i[i] is set.
module mem_byte_merge (
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_word_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between fetch and load/store ports; grant in N, response in N+2 (N+3 for partial stores).
// Requesters hold their request until gnt, which is only issued in IDLE; fetch waits at most STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              store_q, store_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              gnt_if, gnt_d, data_wins;
  logic [DATA_W-1:0] merged;

  mem_byte_merge u_merge (
    .old_word_i (bus.mem_rdata),
    .new_word_i (mem_wdata_q),
    .be_i       (be_q),
    .merged_o   (merged)
  );

  // Data has priority unless fetch has already been passed over STARVE_LIMIT times.
  assign data_wins = bus.d_req && !(bus.if_req && (starve_q == LIMIT));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    be_d        = be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    gnt_if      = 1'b0;
    gnt_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // Gating with resetn keeps both grants low while reset is held.
        if (resetn && (bus.d_req || bus.if_req)) begin
          state_d = ACCESS;
          if (data_wins) begin
            gnt_d       = 1'b1;
            owner_d     = OWN_D;
            store_d     = bus.d_we;
            be_d        = bus.d_be;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_we_d    = bus.d_we && (bus.d_be == BE_FULL);
          end else begin
            gnt_if     = 1'b1;
            owner_d    = OWN_IF;
            store_d    = 1'b0;
            be_d       = BE_NONE;
            mem_addr_d = bus.if_addr;
            mem_we_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        if (owner_q == OWN_D && store_q && be_q != BE_FULL && be_q != BE_NONE) begin
          mem_wdata_d = merged;
          mem_we_d    = 1'b1;
          state_d     = MERGE;
        end else begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = bus.mem_rdata;
            if_rvalid_d = 1'b1;
          end else begin
            if (!store_q) d_rdata_d = bus.mem_rdata;
            d_rvalid_d = 1'b1;
          end
        end
      end
      MERGE: begin
        mem_we_d   = 1'b0;
        d_rvalid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || gnt_if)         starve_d = '0;
    else if (gnt_d && starve_q != LIMIT) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      be_q        <= BE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      be_q        <= be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
